// File: rtl/wallace_reduce_pipe.sv
// wallace_reduce_pipe: CSA-tree reduction of four radix-4 Booth partial-product rows
// and a final carry-propagate add, in a 2-stage valid/ready pipeline.
module wallace_reduce_pipe #(
    parameter int PP_W = 9,
    parameter int P_W  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PP_W-1:0] PP1,
    input  logic [PP_W-1:0] PP2,
    input  logic [PP_W-1:0] PP3,
    input  logic [PP_W-1:0] PP4,
    input  logic [3:0]      sign,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [P_W-1:0]  product
);
    logic [P_W-1:0] r0, r1, r2, r3, sv;
    logic [P_W-1:0] l1_s, l1_c, l2_s, l2_c, l3_s, l3_c;
    logic [P_W-1:0] s1_sum, s1_carry;
    logic           s1_valid, s1_adv, s2_adv;
    // Each row's MSB is inverted; the constant -sum(2^(8+2i)) = 0xAB00 that this leaves
    // is folded into row 0's upper bits together with its own inverted MSB.
    always_comb begin
        r0 = {5'b10101, ~PP1[PP_W-1], PP1[PP_W-1], PP1[PP_W-1], PP1[PP_W-2:0]};
        r1 = {5'b0, ~PP2[PP_W-1], PP2[PP_W-2:0], 2'b0};
        r2 = {3'b0, ~PP3[PP_W-1], PP3[PP_W-2:0], 4'b0};
        r3 = {1'b0, ~PP4[PP_W-1], PP4[PP_W-2:0], 6'b0};
        sv = {9'b0, sign[3], 1'b0, sign[2], 1'b0, sign[1], 1'b0, sign[0]};
        l1_s = r0 ^ r1 ^ r2;
        l1_c = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
        l2_s = l1_s ^ l1_c ^ r3;
        l2_c = ((l1_s & l1_c) | (l1_s & r3) | (l1_c & r3)) << 1;
        // Column 6 is five bits deep, so the sign vector enters a third 3:2 level.
        l3_s = l2_s ^ l2_c ^ sv;
        l3_c = (l2_s & l2_c) | (l2_s & sv) | (l2_c & sv);
    end
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv || flush;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            s1_sum    <= '0;
            s1_carry  <= '0;
            product   <= '0;
        end else begin
            if (flush) begin
                s1_valid  <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                if (s1_adv) s1_valid <= in_valid;
                if (s2_adv) out_valid <= s1_valid;
            end
            if (s1_adv && in_valid) begin
                s1_sum   <= l3_s;
                s1_carry <= l3_c;
            end
            if (s2_adv && s1_valid) product <= s1_sum + (s1_carry << 1);
        end
    end
endmodule

// File: tb/tb_wallace_reduce_pipe.sv
// tb_wallace_reduce_pipe: directed checks of the Booth reduction pipeline, with a
// Booth partial-product generator and signed-multiply reference inside the bench.
module tb_wallace_reduce_pipe;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [8:0]  PP1, PP2, PP3, PP4;
    logic [3:0]  sign;
    logic [15:0] product;
    int          vecs = 0, errs = 0;
    logic [15:0] q[$];
    logic        hold = 1'b0, saw_stall = 1'b0, ac;
    logic [15:0] held;
    int          idx;
    logic signed [7:0] ca[4] = '{-8'sd128, 8'sd127, -8'sd1, 8'sd0};
    logic signed [7:0] cb[4] = '{-8'sd128, -8'sd128, -8'sd1, -8'sd77};
    logic [15:0]       ce[4] = '{16'h4000, 16'hC080, 16'h0001, 16'h0000};

    wallace_reduce_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .PP1(PP1), .PP2(PP2), .PP3(PP3), .PP4(PP4), .sign(sign),
        .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic signed [7:0] a, input logic signed [7:0] b);
        logic [8:0]  bx, m;
        logic [2:0]  t;
        logic [35:0] rows;
        logic [3:0]  sg;
        bx = {b, 1'b0};
        for (int i = 0; i < 4; i++) begin
            t = bx[2*i+2 -: 3];
            m = (t == 3'b011 || t == 3'b100) ? {a, 1'b0} :
                (t == 3'b000 || t == 3'b111) ? 9'd0 : {a[7], a};
            sg[i] = t[2] && t != 3'b111;
            rows[9*i +: 9] = sg[i] ? ~m : m;
        end
        {PP4, PP3, PP2, PP1} = rows;
        sign = sg;
    endtask

    task automatic step(input logic iv, input logic signed [7:0] a, input logic signed [7:0] b,
                        input logic ordy, output logic acc);
        logic signed [15:0] sa, sb;
        in_valid  = iv;
        out_ready = ordy;
        if (iv) drive(a, b);
        else begin
            {PP4, PP3, PP2, PP1} = 'x;
            sign = 'x;
        end
        #1;
        chk("in_ready", {15'b0, in_ready}, {15'b0, !(q.size() == 2 && !ordy)});
        if (!in_ready) saw_stall = 1'b1;
        if (hold) begin
            chk("hold_valid", {15'b0, out_valid}, 16'd1);
            chk("hold_product", product, held);
        end
        if (out_valid && ordy) begin
            if (q.size() == 0) chk("spurious_out", {15'b0, out_valid}, 16'd0);
            else chk("stream_product", product, q.pop_front());
        end
        hold = out_valid && !ordy;
        held = product;
        acc  = iv && in_ready;
        tick();
        sa = a;
        sb = b;
        if (acc) q.push_back(sa * sb);
    endtask

    initial begin
        // reset state, then a single 3*5 beat
        #12;
        chk("rst_product", product, 16'h0000);
        chk("rst_out_valid", {15'b0, out_valid}, 16'd0);
        chk("rst_in_ready", {15'b0, in_ready}, 16'd1);
        rst_n = 1'b1;
        drive(8'sd3, 8'sd5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_s1_only", {15'b0, out_valid}, 16'd0);
        tick();
        chk("lat_out_valid", {15'b0, out_valid}, 16'd1);
        chk("lat_product", product, 16'h000F);
        tick();
        chk("lat_out_drop", {15'b0, out_valid}, 16'd0);

        // corner operands back to back
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                drive(ca[k], cb[k]);
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            tick();
            if (k >= 1) begin
                chk("corner_valid", {15'b0, out_valid}, 16'd1);
                chk("corner_product", product, ce[k-1]);
            end
        end
        tick();
        chk("corner_drain", {15'b0, out_valid}, 16'd0);

        // five beats with out_ready low for four cycles from cycle 2
        idx = 0;
        for (int s = 0; s < 12; s++) begin
            step(idx < 5, 8'(7*idx - 20), 8'(13 - 5*idx), !(s >= 2 && s < 6), ac);
            if (ac) idx++;
        end
        chk("bp_accepted", 16'(idx), 16'd5);
        chk("bp_all_delivered", 16'(q.size()), 16'd0);
        chk("bp_stall_seen", {15'b0, saw_stall}, 16'd1);

        // flush with both stages full and a beat offered
        step(1'b1, 8'sd11, 8'sd13, 1'b0, ac);
        step(1'b1, -8'sd9, 8'sd7, 1'b0, ac);
        drive(8'sd100, 8'sd100);
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", {15'b0, in_ready}, 16'd1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        q.delete();
        hold = 1'b0;
        chk("flush_out_valid", {15'b0, out_valid}, 16'd0);
        drive(8'sd2, -8'sd3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("flush_s1_cleared", {15'b0, out_valid}, 16'd0);
        tick();
        chk("post_flush_valid", {15'b0, out_valid}, 16'd1);
        chk("post_flush_product", product, 16'hFFFA);
        tick();
        chk("post_flush_drain", {15'b0, out_valid}, 16'd0);

        // asynchronous reset in the middle of a stall
        step(1'b1, 8'sd50, 8'sd60, 1'b0, ac);
        step(1'b1, -8'sd70, 8'sd80, 1'b0, ac);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {15'b0, out_valid}, 16'd0);
        chk("async_rst_product", product, 16'h0000);
        chk("async_rst_in_ready", {15'b0, in_ready}, 16'd1);
        #1;
        rst_n = 1'b1;
        q.delete();
        hold = 1'b0;
        tick();

        // random operands, in_valid and out_ready
        for (int s = 0; s < 600; s++)
            step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), $urandom_range(0, 2) != 0, ac);
        for (int s = 0; s < 4; s++) step(1'b0, 8'sd0, 8'sd0, 1'b1, ac);
        chk("random_drained", 16'(q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
